// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage: state codes and default bundle widths.
package pipe_pkg;

    // Default widths of the data bundle (pc, operands, imm, alu result) and the control bundle.
    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_CTRL_W = 8;

    // Stage occupancy states; the numeric code equals the number of entries held.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the skid stage: a data bundle plus a control bundle.
// The control bundle can be cleared on its own so a squashed entry can never
// assert a write enable, while the data bundle is simply left in place.
module pipe_slot #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clr_ctrl,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic [DATA_W-1:0] q_data,
    output logic [CTRL_W-1:0] q_ctrl
);

    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;

    // Capture the data bundle on load; it is never cleared except by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (load) begin
            r_data <= d_data;
        end
    end

    // Capture the control bundle on load; a clear takes priority and zeroes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl <= '0;
        end else if (clr_ctrl) begin
            r_ctrl <= '0;
        end else if (load) begin
            r_ctrl <= d_ctrl;
        end
    end

    assign q_data = r_data;
    assign q_ctrl = r_ctrl;

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage register with valid/ready handshake, a two-entry skid
// buffer so ready can be registered without losing throughput, a synchronous
// flush for branch/jump squash and a saturating count of squashed entries.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  drop_count
);

    localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

    pipe_state_t       r_state;
    pipe_state_t       w_next_state;
    logic              r_in_ready;
    logic [CNT_W-1:0]  r_drop_count;

    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_out_valid;
    logic              w_load_main;
    logic              w_load_skid;
    logic              w_main_from_skid;

    logic [DATA_W-1:0] w_main_d_data;
    logic [CTRL_W-1:0] w_main_d_ctrl;
    logic [DATA_W-1:0] w_main_q_data;
    logic [CTRL_W-1:0] w_main_q_ctrl;
    logic [DATA_W-1:0] w_skid_q_data;
    logic [CTRL_W-1:0] w_skid_q_ctrl;

    logic [1:0]        w_drop_add;
    logic [CNT_W+1:0]  w_drop_sum;

    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_in_fire   = in_valid & r_in_ready;
    assign w_out_fire  = w_out_valid & out_ready;

    // Next-state and slot-load decisions; flush empties the stage regardless of handshakes.
    always_comb begin
        w_next_state     = r_state;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        if (flush) begin
            w_next_state = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_next_state = ST_ONE;
                        w_load_main  = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_load_main = 1'b1;
                    end else if (w_in_fire) begin
                        w_next_state = ST_FULL;
                        w_load_skid  = 1'b1;
                    end else if (w_out_fire) begin
                        w_next_state = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_next_state     = ST_ONE;
                        w_load_main      = 1'b1;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: begin
                    w_next_state = ST_EMPTY;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Ready is registered from the next state, so the skid slot absorbs the one in-flight entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready <= 1'b1;
        end else begin
            r_in_ready <= (w_next_state != ST_FULL);
        end
    end

    // Entries lost to a flush: everything held except what leaves this cycle, plus any accepted input.
    assign w_drop_add = 2'(r_state) - {1'b0, w_out_fire} + {1'b0, w_in_fire};
    assign w_drop_sum = {2'b00, r_drop_count} + {{CNT_W{1'b0}}, w_drop_add};

    // Saturating drop counter, updated only on flush cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_count <= '0;
        end else if (flush) begin
            r_drop_count <= (w_drop_sum > CNT_MAX) ? {CNT_W{1'b1}} : w_drop_sum[CNT_W-1:0];
        end
    end

    assign w_main_d_data = w_main_from_skid ? w_skid_q_data : in_data;
    assign w_main_d_ctrl = w_main_from_skid ? w_skid_q_ctrl : in_ctrl;

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main_slot (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load_main),
        .clr_ctrl (flush),
        .d_data   (w_main_d_data),
        .d_ctrl   (w_main_d_ctrl),
        .q_data   (w_main_q_data),
        .q_ctrl   (w_main_q_ctrl)
    );

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid_slot (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load_skid),
        .clr_ctrl (flush),
        .d_data   (in_data),
        .d_ctrl   (in_ctrl),
        .q_data   (w_skid_q_data),
        .q_ctrl   (w_skid_q_ctrl)
    );

    assign in_ready   = r_in_ready;
    assign out_valid  = w_out_valid;
    assign out_data   = w_main_q_data;
    assign out_ctrl   = w_main_q_ctrl & {CTRL_W{w_out_valid}};
    assign occupancy  = 2'(r_state);
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: a queue-based model checked every
// cycle, plus directed vectors with literal expectations.
module tb_pipe_skid_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic [7:0]  in_ctrl;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [7:0]  out_ctrl;
    logic [1:0]  occupancy;
    logic [7:0]  drop_count;

    logic        in_ready2;
    logic        out_valid2;
    logic [31:0] out_data2;
    logic [7:0]  out_ctrl2;
    logic [1:0]  occupancy2;
    logic [1:0]  drop_count2;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct packed {
        logic [31:0] d;
        logic [7:0]  c;
    } entry_t;

    entry_t mq[$];
    bit     mReady;
    int     mDrop;

    pipe_skid_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .occupancy(occupancy), .drop_count(drop_count)
    );

    pipe_skid_stage #(.CNT_W(2)) dutSat (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_ctrl(out_ctrl2),
        .occupancy(occupancy2), .drop_count(drop_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value and record the outcome.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Set the inputs seen at the next rising edge.
    task automatic applyStimulus(input logic iv, input logic [31:0] d, input logic [7:0] c,
                                 input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: a FIFO of at most two entries, ready decided after each edge.
    always @(posedge clk or posedge rst) begin
        bit inF, outF;
        int lost;
        if (rst) begin
            mq.delete();
            mReady = 1'b1;
            mDrop  = 0;
        end else begin
            inF  = in_valid && mReady;
            outF = out_ready && (mq.size() > 0);
            if (flush) begin
                lost  = mq.size() - int'(outF) + int'(inF);
                mDrop = (mDrop + lost > 255) ? 255 : mDrop + lost;
                mq.delete();
                mReady = 1'b1;
            end else begin
                if (outF) void'(mq.pop_front());
                if (inF) mq.push_back('{d: in_data, c: in_ctrl});
                mReady = (mq.size() < 2);
            end
        end
    end

    // Per-cycle comparison of the main DUT against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("model.out_valid", out_valid, mq.size() > 0);
            checkOutput("model.occupancy", occupancy, mq.size());
            checkOutput("model.in_ready", in_ready, mReady);
            checkOutput("model.drop_count", drop_count, mDrop);
            if (mq.size() > 0) begin
                checkOutput("model.out_data", out_data, mq[0].d);
                checkOutput("model.out_ctrl", out_ctrl, mq[0].c);
            end else begin
                checkOutput("model.out_ctrl_empty", out_ctrl, 0);
            end
        end
    end

    initial begin
        applyStimulus(1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        rst = 1'b1;
        #3;
        checkOutput("reset.out_valid", out_valid, 0);
        checkOutput("reset.in_ready", in_ready, 1);
        checkOutput("reset.occupancy", occupancy, 0);
        checkOutput("reset.drop_count", drop_count, 0);
        checkOutput("reset.out_ctrl", out_ctrl, 0);
        #9 rst = 1'b0;
        tick;

        // Fill/drain with downstream always ready.
        applyStimulus(1'b1, 32'h11, 8'h81, 1'b1, 1'b0); tick;
        checkOutput("fill.data0", out_data, 32'h11);
        checkOutput("fill.occ0", occupancy, 1);
        applyStimulus(1'b1, 32'h22, 8'h82, 1'b1, 1'b0); tick;
        checkOutput("fill.data1", out_data, 32'h22);
        checkOutput("fill.ready1", in_ready, 1);
        applyStimulus(1'b1, 32'h33, 8'h83, 1'b1, 1'b0); tick;
        checkOutput("fill.data2", out_data, 32'h33);
        checkOutput("fill.ctrl2", out_ctrl, 8'h83);
        applyStimulus(1'b0, 32'h0, 8'h0, 1'b1, 1'b0); tick;
        checkOutput("drain.valid", out_valid, 0);
        checkOutput("drain.ctrl", out_ctrl, 0);

        // Backpressure: second entry lands in the skid slot.
        applyStimulus(1'b1, 32'hA0, 8'h0F, 1'b0, 1'b0); tick;
        checkOutput("bp.occ1", occupancy, 1);
        applyStimulus(1'b1, 32'hA1, 8'h1F, 1'b0, 1'b0); tick;
        checkOutput("bp.occ2", occupancy, 2);
        checkOutput("bp.ready", in_ready, 0);
        checkOutput("bp.data", out_data, 32'hA0);
        applyStimulus(1'b0, 32'h0, 8'h0, 1'b1, 1'b0); tick;
        checkOutput("bp.next", out_data, 32'hA1);
        checkOutput("bp.nextctrl", out_ctrl, 8'h1F);
        checkOutput("bp.readyback", in_ready, 1);
        tick;
        checkOutput("bp.empty", occupancy, 0);

        // Streaming eight entries without bubbles.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 32'h100 + i, 8'(i), 1'b1, 1'b0); tick;
            checkOutput("stream.data", out_data, 32'h100 + i);
            checkOutput("stream.occ", occupancy, 1);
        end
        applyStimulus(1'b0, 32'h0, 8'h0, 1'b1, 1'b0); tick;

        // Flush while full with an offered input that cannot be accepted.
        applyStimulus(1'b1, 32'hB0, 8'hFF, 1'b0, 1'b0); tick;
        applyStimulus(1'b1, 32'hB1, 8'hFE, 1'b0, 1'b0); tick;
        applyStimulus(1'b1, 32'hB2, 8'hFD, 1'b0, 1'b1); tick;
        checkOutput("flushfull.valid", out_valid, 0);
        checkOutput("flushfull.ctrl", out_ctrl, 0);
        checkOutput("flushfull.occ", occupancy, 0);
        checkOutput("flushfull.drop", drop_count, 2);
        checkOutput("flushfull.ready", in_ready, 1);

        // Flush in ONE with simultaneous in_fire and out_fire: only the incoming entry is lost.
        applyStimulus(1'b1, 32'hC0, 8'h55, 1'b0, 1'b0); tick;
        applyStimulus(1'b1, 32'hC1, 8'h56, 1'b1, 1'b1); tick;
        checkOutput("flushone.drop", drop_count, 3);
        checkOutput("flushone.occ", occupancy, 0);
        applyStimulus(1'b0, 32'h0, 8'h0, 1'b0, 1'b0); tick;

        // Saturation on the narrow counter after a clean reset.
        rst = 1'b1; tick; rst = 1'b0; tick;
        for (int r = 0; r < 3; r++) begin
            applyStimulus(1'b1, 32'hD0 + 2 * r, 8'h11, 1'b0, 1'b0); tick;
            applyStimulus(1'b1, 32'hD1 + 2 * r, 8'h22, 1'b0, 1'b0); tick;
            applyStimulus(1'b0, 32'h0, 8'h0, 1'b0, 1'b1); tick;
            checkOutput("sat.narrow", drop_count2, (r == 0) ? 2 : 3);
            checkOutput("sat.wide", drop_count, 2 * (r + 1));
        end
        applyStimulus(1'b0, 32'h0, 8'h0, 1'b0, 1'b0); tick;

        // Asynchronous reset while full, checked before the next edge.
        applyStimulus(1'b1, 32'hE0, 8'h3C, 1'b0, 1'b0); tick;
        applyStimulus(1'b1, 32'hE1, 8'h3D, 1'b0, 1'b0); tick;
        checkOutput("async.pre_occ", occupancy, 2);
        applyStimulus(1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        checkOutput("async.valid", out_valid, 0);
        checkOutput("async.occ", occupancy, 0);
        checkOutput("async.ready", in_ready, 1);
        checkOutput("async.drop", drop_count, 0);
        #3 rst = 1'b0;
        tick;
        tick;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
